freq_meter_mc: RTL and testbench
================================

Name: freq_meter_mc

Overview:
Multi-channel gated frequency meter. It counts rising edges on NUM_CH asynchronous input signals over a programmable gate window, measured in clk cycles. At the end of each window it publishes one saturated count per channel with a one-cycle valid strobe. It supports continuous back-to-back windows or single-shot measurement, and sits between raw sensor/clock-probe inputs and a status/register block.

Parameters:
NUM_CH, 2, number of independent measured input channels
CNT_W, 16, width of each per-channel edge count
GATE_W, 16, width of the gate-length input
SYNC_STAGES, 2, synchronizer flops per channel (minimum 2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
en  input  1  block enable; low aborts any window
mode  input  1  0 = continuous, 1 = single-shot
start  input  1  single-shot trigger pulse (used only when mode=1)
gate_len  input  GATE_W  window length in clk cycles
sig_in  input  NUM_CH  asynchronous signals to measure
count_out  output  NUM_CH*CNT_W  last published counts; channel k at bits [k*CNT_W +: CNT_W]
valid  output  1  one-cycle strobe when count_out updates
busy  output  1  high while a window is active
overflow  output  NUM_CH  per-channel saturation flag for the last published window

Behaviour:
- Reset: all outputs = 0; FSM = IDLE; synchronizers, edge-history flops, counters and gate timer = 0.
- Input path per channel: SYNC_STAGES-flop synchronizer followed by a rising-edge detect (sync & ~prev). Both run every cycle regardless of en or state.
  - Detected edge lags sig_in by SYNC_STAGES+1 cycles.
  - An input already high at reset release yields one detected edge; it counts only if a window is active.
- FSM states:
  - IDLE -> MEASURE when en=1 and (mode=0, or mode=1 and start=1).
  - MEASURE -> MEASURE (new window) at window end when mode latched = 0 and en=1.
  - MEASURE -> IDLE at window end when mode latched = 1.
  - MEASURE -> IDLE immediately when en=0 (abort).
- Window start: gate_len and mode are latched. A latched length G=0 is treated as G=1. Counters start at 0, and the first window cycle is the cycle after the transition.
- Window is exactly G cycles. An edge detected in any window cycle, including the last, increments that channel's counter.
- Counter saturates at 2^CNT_W-1; further edges set that channel's pending overflow bit.
- Last window cycle, registered on the following edge:
  - count_out[k] <= saturated (cnt[k] + edge[k]); overflow[k] <= pending or saturation on the final add.
  - valid = 1 for exactly that one cycle.
  - Counters and pending flags clear.
- Continuous mode: the next window's first cycle is that same following cycle (zero gap). An edge detected then belongs to the new window.
- busy = 1 in MEASURE. In continuous mode busy does not drop between windows.
- start while busy: ignored. start in mode 0: ignored. mode/gate_len changes mid-window take effect at the next window start.
- Abort (en=0 mid-window): no valid; count_out/overflow keep their last published values; counters clear; busy=0 next cycle.
- Reset mid-window: asynchronous clear of everything to the reset values above.

Test Plan:
- Defaults, mode=0, gate_len=80, sig_in[0] period 8 cycles, sig_in[1] period 16 cycles -> each valid carries ch0=10, ch1=5; valid pulses exactly every 80 cycles; busy stays 1.
- mode=1, gate_len=40, one start pulse, sig_in[0] period 4 -> single valid with ch0=10, busy high for 40 cycles then 0; a second start while busy is ignored.
- CNT_W=4, gate_len=40, sig_in[0] toggling every cycle (20 edges) -> ch0=15, overflow[0]=1, overflow[1]=0; the next window with 6 edges gives ch0=6, overflow[0]=0.
- gate_len=0 in mode=1, a single sig_in edge aligned to the window cycle -> window of 1 cycle, count 1, valid 1 cycle after busy.
- en dropped at cycle 30 of an 80-cycle window -> no valid, count_out unchanged from the prior window, busy=0 the next cycle; en re-raised starts a fresh full window.
- reset asserted mid-window asynchronously (between clock edges) -> count_out, valid, busy, overflow = 0 immediately; after release, the measurement resumes per mode/en.

Source files
------------

// File: rtl/freq_meter_mc.sv
// freq_meter_mc: multi-channel gated frequency meter.
// Counts rising edges on NUM_CH asynchronous inputs over a window of G clk
// cycles. At the end of each window it publishes one saturated count per
// channel, together with a one-cycle valid strobe. It runs either in
// continuous mode (back-to-back windows) or in single-shot mode.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   en         block enable; low aborts the active window
//   mode       0 = continuous, 1 = single-shot (latched at window start)
//   start      single-shot trigger, sampled only in IDLE with mode=1
//   gate_len   window length in clk cycles (0 is treated as 1)
//   sig_in     asynchronous inputs to measure
//   count_out  last published counts, channel k at [k*CNT_W +: CNT_W]
//   valid      one-cycle strobe when count_out/overflow update
//   busy       high while a window is active
//   overflow   per-channel saturation flag of the last published window
//
// state   | meaning
// IDLE    | no window active; waiting for en (and start in single-shot mode)
// MEASURE | window active; timer counts down to 0 on the last window cycle
module freq_meter_mc #(
   parameter int NUM_CH      = 2,
   parameter int CNT_W       = 16,
   parameter int GATE_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    mode,
   input  logic                    start,
   input  logic [GATE_W-1:0]       gate_len,
   input  logic [NUM_CH-1:0]       sig_in,
   output logic [NUM_CH*CNT_W-1:0] count_out,
   output logic                    valid,
   output logic                    busy,
   output logic [NUM_CH-1:0]       overflow
);

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_MEASURE = 1'b1;

   // A single flop is never a safe synchronizer, so clamp to two.
   localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [SS-1:0][NUM_CH-1:0]    sync_q, sync_d;
   logic [NUM_CH-1:0]            prev_q, prev_d;
   logic [NUM_CH-1:0]            edge_det;

   logic [0:0]                   state_q, state_d;
   logic                         mode_lat_q, mode_lat_d;
   logic [GATE_W-1:0]            timer_q, timer_d;
   logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d, cnt_next;
   logic [NUM_CH-1:0]            pend_q, pend_d, pend_next;
   logic [NUM_CH-1:0][CNT_W-1:0] count_q, count_d;
   logic [NUM_CH-1:0]            ovf_q, ovf_d;
   logic                         valid_q, valid_d;
   logic                         start_win;

   // Input path runs every cycle, independent of en and state.
   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = sig_in;
      for (int i = 1; i < SS; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      prev_d   = sync_q[SS-1];
      edge_det = sync_q[SS-1] & ~prev_q;
   end

   // Saturating per-channel increment; an edge lost to saturation is
   // remembered in pend so the published overflow flag reflects it.
   always_comb begin
      cnt_next  = cnt_q;
      pend_next = pend_q;
      for (int k = 0; k < NUM_CH; k++) begin
         if (edge_det[k]) begin
            if (cnt_q[k] == CNT_MAX) begin
               pend_next[k] = 1'b1;
            end else begin
               cnt_next[k] = cnt_q[k] + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      mode_lat_d = mode_lat_q;
      timer_d    = timer_q;
      cnt_d      = cnt_q;
      pend_d     = pend_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      valid_d    = 1'b0;
      start_win  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (en && (!mode || start)) begin
               start_win = 1'b1;
            end
         end
         ST_MEASURE: begin
            if (!en) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               pend_d  = '0;
            end else if (timer_q == '0) begin
               count_d = cnt_next;
               ovf_d   = pend_next;
               valid_d = 1'b1;
               cnt_d   = '0;
               pend_d  = '0;
               if (!mode_lat_q) begin
                  start_win = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d   = cnt_next;
               pend_d  = pend_next;
               timer_d = timer_q - GATE_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Timer holds G-1 so that it reaches zero on the G-th window cycle.
      if (start_win) begin
         state_d    = ST_MEASURE;
         mode_lat_d = mode;
         timer_d    = (gate_len == '0) ? '0 : gate_len - GATE_W'(1);
         cnt_d      = '0;
         pend_d     = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q     <= '0;
         prev_q     <= '0;
         state_q    <= ST_IDLE;
         mode_lat_q <= 1'b0;
         timer_q    <= '0;
         cnt_q      <= '0;
         pend_q     <= '0;
         count_q    <= '0;
         ovf_q      <= '0;
         valid_q    <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         prev_q     <= prev_d;
         state_q    <= state_d;
         mode_lat_q <= mode_lat_d;
         timer_q    <= timer_d;
         cnt_q      <= cnt_d;
         pend_q     <= pend_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         valid_q    <= valid_d;
      end
   end

   assign count_out = count_q;
   assign overflow  = ovf_q;
   assign valid     = valid_q;
   assign busy      = (state_q == ST_MEASURE);

endmodule

// File: tb/tb_freq_meter_mc.sv
// Bench for freq_meter_mc (NUM_CH=2, CNT_W=4 so saturation is easy to reach).
module tb_freq_meter_mc;
   localparam int NCH = 2;
   localparam int CW  = 4;
   localparam int GW  = 16;
   localparam int NR  = 1500;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            en = 1'b0;
   logic            mode = 1'b0;
   logic            start = 1'b0;
   logic [GW-1:0]   gate_len = '0;
   logic [NCH-1:0]  sig_in = '0;
   logic [NCH*CW-1:0] count_out;
   logic            valid;
   logic            busy;
   logic [NCH-1:0]  overflow;

   freq_meter_mc #(.NUM_CH(NCH), .CNT_W(CW), .GATE_W(GW), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .start(start),
      .gate_len(gate_len), .sig_in(sig_in), .count_out(count_out),
      .valid(valid), .busy(busy), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   bit auto_sig = 1'b0;
   int ph = 0;
   int per0 = 8;
   int per1 = 16;

   typedef struct {
      int gate; int p0; int p1; int e0; int e1; int o0; int o1;
   } row_t;
   row_t rows[6];

   logic [NCH-1:0] sh [0:NR+4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   function automatic int ch(input int k);
      return int'(count_out[k*CW +: CW]);
   endfunction

   // Periodic square waves: exactly one rising edge per period, so any
   // G consecutive cycles with G a multiple of the period contain G/P edges.
   task automatic tick();
      if (auto_sig) begin
         sig_in[0] = ((ph % per0) < (per0 / 2));
         sig_in[1] = ((ph % per1) < (per1 / 2));
         ph++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int limit, output int n, output int nbusy);
      n = 0;
      nbusy = 0;
      while (n < limit) begin
         tick();
         n++;
         if (busy) nbusy++;
         if (valid) break;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      en = 1'b0;
      start = 1'b0;
      repeat (3) tick();
      chk("rst_count", count_out, 0);
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", overflow, 0);
      reset = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, nb, nv, nbt;
      int act, p0, pe, raw0, raw1, e0, e1, o0, o1;
      logic lm, exp_valid;

      rows[0] = '{40, 4, 8, 10, 5, 0, 0};
      rows[1] = '{40, 2, 10, 15, 4, 1, 0};
      rows[2] = '{24, 4, 6, 6, 4, 0, 0};
      rows[3] = '{32, 2, 2, 15, 15, 1, 1};
      rows[4] = '{30, 2, 3, 15, 10, 0, 0};
      rows[5] = '{12, 6, 4, 2, 3, 0, 0};

      do_reset();

      // Continuous mode, gate 80, periods 8 and 16.
      auto_sig = 1'b1; per0 = 8; per1 = 16;
      repeat (6) tick();
      mode = 1'b0; gate_len = 80; en = 1'b1;
      wait_valid(100, n, nb);
      chk("cont_first_latency", n, 81);
      for (int w = 0; w < 3; w++) begin
         wait_valid(100, n, nb);
         chk("cont_period", n, 80);
         chk("cont_busy_held", nb, 80);
         chk("cont_ch0", ch(0), 10);
         chk("cont_ch1", ch(1), 5);
         chk("cont_ovf", overflow, 0);
      end

      // Abort at window cycle 30.
      repeat (29) tick();
      en = 1'b0;
      tick();
      chk("abort_busy", busy, 0);
      chk("abort_valid", valid, 0);
      nv = 0; nbt = 0;
      repeat (100) begin
         tick();
         if (valid) nv++;
         if (busy) nbt++;
      end
      chk("abort_no_valid", nv, 0);
      chk("abort_idle", nbt, 0);
      chk("abort_ch0_kept", ch(0), 10);
      chk("abort_ch1_kept", ch(1), 5);
      en = 1'b1;
      wait_valid(100, n, nb);
      chk("reen_latency", n, 81);
      chk("reen_ch0", ch(0), 10);
      chk("reen_ch1", ch(1), 5);

      // Single-shot table.
      en = 1'b0;
      repeat (2) tick();
      mode = 1'b1; en = 1'b1; start = 1'b0;
      repeat (3) tick();
      chk("ss_idle_no_start", busy, 0);
      for (int r = 0; r < 6; r++) begin
         per0 = rows[r].p0; per1 = rows[r].p1; gate_len = GW'(rows[r].gate);
         repeat (5) tick();
         start = 1'b1;
         tick();
         start = 1'b0;
         chk("ss_busy_start", busy, 1);
         wait_valid(rows[r].gate + 5, n, nb);
         chk("ss_valid_seen", valid, 1);
         chk("ss_len", n, rows[r].gate);
         chk("ss_busy_len", nb, rows[r].gate - 1);
         chk("ss_busy_end", busy, 0);
         chk("ss_ch0", ch(0), rows[r].e0);
         chk("ss_ch1", ch(1), rows[r].e1);
         chk("ss_ovf0", overflow[0], rows[r].o0);
         chk("ss_ovf1", overflow[1], rows[r].o1);
      end

      // start while busy is ignored.
      per0 = 4; per1 = 8; gate_len = 40;
      repeat (5) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      nbt = busy ? 1 : 0;
      repeat (10) begin tick(); if (busy) nbt++; end
      start = 1'b1;
      tick();
      start = 1'b0;
      if (busy) nbt++;
      wait_valid(60, n, nb);
      nbt += nb;
      chk("sib_valid_seen", valid, 1);
      chk("sib_busy_total", nbt, 40);
      chk("sib_ch0", ch(0), 10);
      nv = 0; nb = 0;
      repeat (50) begin tick(); if (valid) nv++; if (busy) nb++; end
      chk("sib_no_restart_valid", nv, 0);
      chk("sib_no_restart_busy", nb, 0);

      // gate_len=0: one-cycle window with one edge aligned to it.
      auto_sig = 1'b0;
      sig_in = '0;
      gate_len = 0;
      repeat (4) tick();
      sig_in = 2'b01;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("g0_busy", busy, 1);
      chk("g0_valid_early", valid, 0);
      tick();
      chk("g0_busy_end", busy, 0);
      chk("g0_valid", valid, 1);
      chk("g0_ch0", ch(0), 1);
      chk("g0_ch1", ch(1), 0);
      tick();
      chk("g0_valid_one_cycle", valid, 0);

      // Asynchronous reset mid-window.
      auto_sig = 1'b1; per0 = 8; per1 = 16;
      mode = 1'b0; gate_len = 80;
      wait_valid(100, n, nb);
      wait_valid(100, n, nb);
      chk("pre_rst_ch0", ch(0), 10);
      repeat (20) tick();
      #3;
      reset = 1'b1;
      #1;
      chk("arst_count", count_out, 0);
      chk("arst_valid", valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_ovf", overflow, 0);
      repeat (2) tick();
      reset = 1'b0;
      wait_valid(100, n, nb);
      chk("post_rst_latency", n, 81);
      wait_valid(100, n, nb);
      chk("post_rst_period", n, 80);
      chk("post_rst_ch0", ch(0), 10);
      chk("post_rst_ch1", ch(1), 5);

      // Randomized run against a window-level reference model.
      auto_sig = 1'b0;
      sig_in = '0;
      do_reset();
      for (int i = 0; i <= NR + 4; i++) sh[i] = '0;
      en = 1'b1;
      act = 0; p0 = 0; pe = 0; lm = 1'b0;
      e0 = 0; e1 = 0; o0 = 0; o1 = 0;
      for (int p = 1; p <= NR; p++) begin
         sig_in   = NCH'($urandom_range(0, 3));
         gate_len = GW'($urandom_range(0, 70));
         mode     = ($urandom_range(0, 3) == 0);
         start    = ($urandom_range(0, 7) == 0);
         sh[p+3]  = sig_in;
         tick();
         exp_valid = 1'b0;
         if (act == 0) begin
            if (!mode || start) begin
               act = 1; p0 = p; lm = mode;
               pe = p + ((gate_len == 0) ? 1 : int'(gate_len));
            end
         end else if (p == pe) begin
            exp_valid = 1'b1;
            raw0 = 0; raw1 = 0;
            // Edge used on clock q: input sampled 2 clocks earlier rose.
            for (int q = p0 + 1; q <= pe; q++) begin
               raw0 += int'(sh[q+1][0] & ~sh[q][0]);
               raw1 += int'(sh[q+1][1] & ~sh[q][1]);
            end
            e0 = (raw0 > 15) ? 15 : raw0; o0 = (raw0 > 15) ? 1 : 0;
            e1 = (raw1 > 15) ? 15 : raw1; o1 = (raw1 > 15) ? 1 : 0;
            if (!lm) begin
               p0 = p; lm = mode;
               pe = p + ((gate_len == 0) ? 1 : int'(gate_len));
            end else begin
               act = 0;
            end
         end
         chk("rnd_valid", valid, exp_valid);
         chk("rnd_busy", busy, act);
         chk("rnd_ch0", ch(0), e0);
         chk("rnd_ch1", ch(1), e1);
         chk("rnd_ovf", overflow, (o1 << 1) | o0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
